// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - fetch handshake and datapath control bundle for control_unit
interface control_unit_if #(
    parameter int WORDSIZE = 64
);
    logic                instr_req;
    logic                instr_valid;
    logic [31:0]         instr_data;
    logic [WORDSIZE-1:0] pc;
    logic [4:0]          ctrl_rf_addr_a;
    logic [4:0]          ctrl_rf_addr_b;
    logic [4:0]          ctrl_rf_write_addr;
    logic                ctrl_rf_write_en;
    logic [11:0]         ctrl_immediate;
    logic                ctrl_mux_0_sel;
    logic                ctrl_mux_1_sel;
    logic                ctrl_mux_2_sel;
    logic [2:0]          ctrl_alu_operation;
    logic                illegal;

    modport master (
        output instr_req, pc, ctrl_rf_addr_a, ctrl_rf_addr_b, ctrl_rf_write_addr,
               ctrl_rf_write_en, ctrl_immediate, ctrl_mux_0_sel, ctrl_mux_1_sel,
               ctrl_mux_2_sel, ctrl_alu_operation, illegal,
        input  instr_valid, instr_data
    );

    modport slave (
        input  instr_req, pc, ctrl_rf_addr_a, ctrl_rf_addr_b, ctrl_rf_write_addr,
               ctrl_rf_write_en, ctrl_immediate, ctrl_mux_0_sel, ctrl_mux_1_sel,
               ctrl_mux_2_sel, ctrl_alu_operation, illegal,
        output instr_valid, instr_data
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle RV64I subset sequencer; CONTROL_UNIT_PERF_EN adds retired_count
module control_unit #(
    parameter int                WORDSIZE = 64,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef CONTROL_UNIT_PERF_EN
    output logic [WORDSIZE-1:0] retired_count,
`endif
    control_unit_if.master      bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LD, C_SD, C_BAD
    } cls_t;

    state_t              state_q, state_d;
    logic [WORDSIZE-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic                illegal_q, illegal_d;
    logic                retire;
    cls_t                cls;
    logic [2:0]          alu_op;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    always_comb begin
        cls    = C_BAD;
        alu_op = 3'b000;
        case (opcode)
            7'b0110011: begin
                cls = C_R;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: alu_op = 3'b000;
                    {7'b0100000, 3'b000}: alu_op = 3'b001;
                    {7'b0000000, 3'b111}: alu_op = 3'b010;
                    {7'b0000000, 3'b110}: alu_op = 3'b011;
                    {7'b0000000, 3'b100}: alu_op = 3'b100;
                    {7'b0000000, 3'b010}: alu_op = 3'b101;
                    default:              cls    = C_BAD;
                endcase
            end
            7'b0010011: begin
                cls = C_I;
                case (funct3)
                    3'b000:  alu_op = 3'b000;
                    3'b111:  alu_op = 3'b010;
                    3'b110:  alu_op = 3'b011;
                    3'b100:  alu_op = 3'b100;
                    3'b010:  alu_op = 3'b101;
                    default: cls    = C_BAD;
                endcase
            end
            7'b0000011: if (funct3 == 3'b011) cls = C_LD;
            7'b0100011: if (funct3 == 3'b011) cls = C_SD;
            default:    cls = C_BAD;
        endcase
        // Unsupported encodings must not leak a stale ALU op into the datapath.
        if (cls == C_BAD) alu_op = 3'b000;
    end

    always_comb begin
        bus.instr_req          = (state_q == S_FETCH);
        bus.pc                 = pc_q;
        bus.illegal            = illegal_q;
        bus.ctrl_rf_addr_a     = ir_q[19:15];
        bus.ctrl_rf_addr_b     = ir_q[24:20];
        bus.ctrl_rf_write_addr = ir_q[11:7];
        bus.ctrl_alu_operation = alu_op;
        bus.ctrl_mux_0_sel     = (cls == C_I) || (cls == C_LD) || (cls == C_SD);
        case (cls)
            C_I, C_LD: bus.ctrl_immediate = ir_q[31:20];
            C_SD:      bus.ctrl_immediate = {ir_q[31:25], ir_q[11:7]};
            default:   bus.ctrl_immediate = 12'h000;
        endcase
        // Writes to x0 are dropped here; sequencing is unaffected.
        bus.ctrl_rf_write_en = (ir_q[11:7] != 5'd0) &&
                               (((state_q == S_EXEC) && ((cls == C_R) || (cls == C_I))) ||
                                (state_q == S_WB));
        bus.ctrl_mux_1_sel   = (state_q == S_WB);
        bus.ctrl_mux_2_sel   = (state_q == S_MEM) && (cls == C_SD);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls == C_BAD) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  if ((cls == C_LD) || (cls == C_SD)) state_d = S_MEM;
                     else retire = 1'b1;
            S_MEM:   if (cls == C_SD) retire = 1'b1;
                     else state_d = S_WB;
            S_WB:    retire = 1'b1;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        if (retire) begin
            pc_d    = pc_q + WORDSIZE'(4);
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef CONTROL_UNIT_PERF_EN
    logic [WORDSIZE-1:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + WORDSIZE'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) retired_q <= '0;
        else        retired_q <= retired_d;
    end

    assign retired_count = retired_q;
`endif
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - table-driven directed bench for control_unit
module tb_control_unit;
    logic clk;
    logic rst_n;
    int   total_checks;
    int   passed_checks;
    logic [63:0] exp_pc;

    control_unit_if #(.WORDSIZE(64)) bus ();

`ifdef CONTROL_UNIT_PERF_EN
    logic [63:0] retired_count;
`endif

    control_unit #(.WORDSIZE(64), .RESET_PC(64'd0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef CONTROL_UNIT_PERF_EN
        .retired_count (retired_count),
`endif
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] imm;
        logic        mux0;
        logic [2:0]  alu;
        int          we_cyc;
        int          mux1_cyc;
        int          mux2_cyc;
        int          last;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic wait_req();
        for (int n = 0; n < 20; n++) begin
            if (bus.instr_req === 1'b1) break;
            @(negedge clk);
        end
        chk("wait_instr_req", 64'(bus.instr_req), 64'd1);
    endtask

    task automatic apply(input int idx);
        vec_t v;
        v = vecs[idx];
        wait_req();
        chk($sformatf("pc_before[%0d]", idx), bus.pc, exp_pc);
        bus.instr_valid = 1'b1;
        bus.instr_data  = v.instr;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr_data  = 32'h0;
        for (int k = 1; k <= v.last; k++) begin
            chk($sformatf("rs1[%0d,%0d]", idx, k), 64'(bus.ctrl_rf_addr_a), 64'(v.rs1));
            chk($sformatf("rs2[%0d,%0d]", idx, k), 64'(bus.ctrl_rf_addr_b), 64'(v.rs2));
            chk($sformatf("rd[%0d,%0d]", idx, k), 64'(bus.ctrl_rf_write_addr), 64'(v.rd));
            chk($sformatf("imm[%0d,%0d]", idx, k), 64'(bus.ctrl_immediate), 64'(v.imm));
            chk($sformatf("mux0[%0d,%0d]", idx, k), 64'(bus.ctrl_mux_0_sel), 64'(v.mux0));
            chk($sformatf("alu[%0d,%0d]", idx, k), 64'(bus.ctrl_alu_operation), 64'(v.alu));
            chk($sformatf("we[%0d,%0d]", idx, k), 64'(bus.ctrl_rf_write_en), 64'(k == v.we_cyc));
            chk($sformatf("mux1[%0d,%0d]", idx, k), 64'(bus.ctrl_mux_1_sel), 64'(k == v.mux1_cyc));
            chk($sformatf("mux2[%0d,%0d]", idx, k), 64'(bus.ctrl_mux_2_sel), 64'(k == v.mux2_cyc));
            chk($sformatf("req_busy[%0d,%0d]", idx, k), 64'(bus.instr_req), 64'd0);
            chk($sformatf("pc_hold[%0d,%0d]", idx, k), bus.pc, exp_pc);
            @(negedge clk);
        end
        exp_pc = exp_pc + 64'd4;
        chk($sformatf("pc_after[%0d]", idx), bus.pc, exp_pc);
        chk($sformatf("req_after[%0d]", idx), 64'(bus.instr_req), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, bus.pc, 64'd0);
        chk({tag, "_req"}, 64'(bus.instr_req), 64'd1);
        chk({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
        chk({tag, "_we"}, 64'(bus.ctrl_rf_write_en), 64'd0);
        chk({tag, "_mux1"}, 64'(bus.ctrl_mux_1_sel), 64'd0);
        chk({tag, "_mux2"}, 64'(bus.ctrl_mux_2_sel), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        total_checks    = 0;
        passed_checks   = 0;
        exp_pc          = 64'd0;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 32'h0;

        //          instr         rs1   rs2   rd    imm      m0    alu     we mux1 mux2 last
        vecs[0] = '{32'h003100B3, 5'd2, 5'd3, 5'd1, 12'h000, 1'b0, 3'b000, 2, 0, 0, 2};   // add x1,x2,x3
        vecs[1] = '{32'hFFF00293, 5'd0, 5'd31, 5'd5, 12'hFFF, 1'b1, 3'b000, 2, 0, 0, 2};  // addi x5,x0,-1
        vecs[2] = '{32'h00813383, 5'd2, 5'd8, 5'd7, 12'h008, 1'b1, 3'b000, 4, 4, 0, 4};   // ld x7,8(x2)
        vecs[3] = '{32'h00713823, 5'd2, 5'd7, 5'd16, 12'h010, 1'b1, 3'b000, 0, 0, 3, 3};  // sd x7,16(x2)
        vecs[4] = '{32'h40628233, 5'd5, 5'd6, 5'd4, 12'h000, 1'b0, 3'b001, 2, 0, 0, 2};   // sub x4,x5,x6
        vecs[5] = '{32'h00A4F433, 5'd9, 5'd10, 5'd8, 12'h000, 1'b0, 3'b010, 2, 0, 0, 2};  // and x8,x9,x10
        vecs[6] = '{32'h7F026193, 5'd4, 5'd16, 5'd3, 12'h7F0, 1'b1, 3'b011, 2, 0, 0, 2};  // ori x3,x4,0x7f0
        vecs[7] = '{32'h00514113, 5'd2, 5'd5, 5'd2, 12'h005, 1'b1, 3'b100, 2, 0, 0, 2};   // xori x2,x2,5
        vecs[8] = '{32'h00D625B3, 5'd12, 5'd13, 5'd11, 12'h000, 1'b0, 3'b101, 2, 0, 0, 2}; // slt x11,x12,x13
        vecs[9] = '{32'h00208033, 5'd1, 5'd2, 5'd0, 12'h000, 1'b0, 3'b000, 0, 0, 0, 2};   // add x0,x1,x2

        do_reset();
        chk_reset_state("reset");
        chk("reset_imm", 64'(bus.ctrl_immediate), 64'd0);
        chk("reset_alu", 64'(bus.ctrl_alu_operation), 64'd0);
        chk("reset_mux0", 64'(bus.ctrl_mux_0_sel), 64'd0);
        chk("reset_rd", 64'(bus.ctrl_rf_write_addr), 64'd0);

        for (int i = 0; i < 10; i++) apply(i);

`ifdef CONTROL_UNIT_PERF_EN
        chk("retired_after_table", retired_count, 64'd10);
`endif

        // Starved fetch: request stays up, pc holds.
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk($sformatf("idle_req[%0d]", n), 64'(bus.instr_req), 64'd1);
            chk($sformatf("idle_pc[%0d]", n), bus.pc, exp_pc);
        end
        apply(9);

        // Unsupported jal traps until reset.
        bus.instr_valid = 1'b1;
        bus.instr_data  = 32'h0000006F;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr_data  = 32'h0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("trap_illegal[%0d]", k), 64'(bus.illegal), 64'd1);
            chk($sformatf("trap_req[%0d]", k), 64'(bus.instr_req), 64'd0);
            chk($sformatf("trap_we[%0d]", k), 64'(bus.ctrl_rf_write_en), 64'd0);
            chk($sformatf("trap_mux2[%0d]", k), 64'(bus.ctrl_mux_2_sel), 64'd0);
            chk($sformatf("trap_pc[%0d]", k), bus.pc, exp_pc);
        end
`ifdef CONTROL_UNIT_PERF_EN
        chk("retired_after_trap", retired_count, 64'd11);
`endif
        do_reset();
        chk_reset_state("trap_reset");
`ifdef CONTROL_UNIT_PERF_EN
        chk("retired_after_reset", retired_count, 64'd0);
`endif
        exp_pc = 64'd0;

        // Reset landing in the MEM phase of a load.
        apply(0);
        bus.instr_valid = 1'b1;
        bus.instr_data  = 32'h00813383;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr_data  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("ld_mem_req", 64'(bus.instr_req), 64'd0);
        chk("ld_mem_pc", bus.pc, 64'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_state("mem_reset");
        @(negedge clk);
        chk("mem_reset_req_hold", 64'(bus.instr_req), 64'd1);
        chk("mem_reset_we_hold", 64'(bus.ctrl_rf_write_en), 64'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
